ysyx_220053_idu_stage: RTL

YSYX_220053_IDU_STAGE -- requirements
Module: ysyx_220053_idu_stage

---
 rtl/ysyx_220053_idu_pkg.sv | 93 +++++++++
 rtl/ysyx_220053_imm_gen.sv | 28 ++
 rtl/ysyx_220053_idu_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_idu_pkg.sv
// Shared decode definitions for the IDU stage: opcodes, immediate formats,
// the registered decode bundle and the func3/func7 legality rules (RV64IM + Zicsr).
package ysyx_220053_idu_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } idu_state_e;

    typedef struct packed {
        logic wen;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic csr;
        logic ecall;
        logic mret;
        logic ebreak;
        logic illegal;
    } idu_flags_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        idu_flags_t flags;
    } idu_bundle_t;

    // With a 6-bit shamt (RV64) func7[0] is part of the shift amount.
    function automatic logic op_imm_legal(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic rv64);
        logic [6:0] hi;
        hi = rv64 ? {f7[6:1], 1'b0} : f7;
        case (f3)
            3'b001:  return hi == F7_BASE;
            3'b101:  return (hi == F7_BASE) || (hi == F7_ALT);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_MUL) ||
               ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    endfunction

    function automatic logic op_imm_w_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f3 == 3'b000) ||
               ((f3 == 3'b001) && (f7 == F7_BASE)) ||
               ((f3 == 3'b101) && ((f7 == F7_BASE) || (f7 == F7_ALT)));
    endfunction

    function automatic logic op_w_legal(input logic [2:0] f3, input logic [6:0] f7);
        return ((f7 == F7_BASE) && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101))) ||
               ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
               ((f7 == F7_MUL) && (f3 != 3'b001) && (f3 != 3'b010) && (f3 != 3'b011));
    endfunction

endpackage

// File: rtl/ysyx_220053_imm_gen.sv
// Combinational immediate generator: selects the instruction's immediate
// field by format and sign-extends it to XLEN.
module ysyx_220053_imm_gen
    import ysyx_220053_idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = XLEN'($signed(instr[31:20]));
            IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            IMM_U:   imm = XLEN'($signed({instr[31:12], 12'h000}));
            IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_220053_idu_stage.sv
// Decode stage: small instruction FIFO with a same-cycle bypass, a registered
// decode bundle, and a RUN/HALT machine. Illegal detection: YSYX_220053_IDU_ILLEGAL_EN.
module ysyx_220053_idu_stage
    import ysyx_220053_idu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_wen,
    output logic            out_load,
    output logic            out_store,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_csr,
    output logic            out_ecall,
    output logic            out_mret,
    output logic            out_ebreak,
    output logic            out_illegal,
    input  logic            flush,
    output logic            halted
);

    localparam int  PW   = $clog2(QDEPTH);
    localparam int  CW   = PW + 1;
    localparam logic RV64 = (XLEN == 64);
`ifdef YSYX_220053_IDU_ILLEGAL_EN
    localparam logic W32_AS_BASE = 1'b0;
`else
    localparam logic W32_AS_BASE = 1'b1;
`endif

    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   qcount;
    idu_state_e      state;

    logic            out_valid_r;
    idu_bundle_t     out_b;
    logic [XLEN-1:0] out_pc_r, out_imm_r;

    // Both sides: a beat moves on a rising edge where valid && ready; the
    // producer holds its data while valid && !ready, and in_ready never
    // depends on out_ready.
    logic in_fire, out_fire, halt_now, can_load, q_empty;
    logic bypass, enq, deq, load;

    assign q_empty  = (qcount == '0);
    assign in_ready = (state == ST_RUN) && (qcount < CW'(QDEPTH));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_r && out_ready;
    assign halt_now = out_fire && out_b.flags.ebreak;
    // Retiring an ebreak freezes everything behind it, so nothing reloads that cycle.
    assign can_load = (state == ST_RUN) && (!out_valid_r || out_fire) && !halt_now;
    assign deq      = can_load && !q_empty;
    assign bypass   = can_load && q_empty && in_fire;
    assign enq      = in_fire && !bypass;
    assign load     = deq || bypass;

    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc, dec_imm;
    imm_fmt_e        dec_fmt;
    idu_bundle_t     dec_b;
    logic            legal;
    logic [2:0]      f3;
    logic [6:0]      f7;

    assign dec_instr = q_empty ? in_instr : q_instr[rd_ptr];
    assign dec_pc    = q_empty ? in_pc    : q_pc[rd_ptr];
    assign f3        = dec_instr[14:12];
    assign f7        = dec_instr[31:25];

    ysyx_220053_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (dec_instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_b       = '0;
        dec_fmt     = IMM_NONE;
        legal       = 1'b0;
        dec_b.rd    = dec_instr[11:7];
        dec_b.rs1   = dec_instr[19:15];
        dec_b.rs2   = dec_instr[24:20];
        dec_b.func3 = f3;
        dec_b.func7 = f7;
        case (dec_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt         = IMM_U;
                dec_b.flags.wen = 1'b1;
                legal           = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt         = IMM_J;
                dec_b.flags.wen = 1'b1;
                dec_b.flags.jal = 1'b1;
                legal           = 1'b1;
            end
            OPC_JALR: begin
                dec_fmt          = IMM_I;
                dec_b.flags.wen  = 1'b1;
                dec_b.flags.jalr = 1'b1;
                legal            = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec_fmt            = IMM_B;
                dec_b.flags.branch = 1'b1;
                legal              = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LOAD: begin
                dec_fmt          = IMM_I;
                dec_b.flags.wen  = 1'b1;
                dec_b.flags.load = 1'b1;
                legal            = (f3 != 3'b111) &&
                                   (RV64 || ((f3 != 3'b011) && (f3 != 3'b110)));
            end
            OPC_STORE: begin
                dec_fmt           = IMM_S;
                dec_b.flags.store = 1'b1;
                legal             = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                    (RV64 && (f3 == 3'b011));
            end
            OPC_OP_IMM: begin
                dec_fmt         = IMM_I;
                dec_b.flags.wen = 1'b1;
                legal           = op_imm_legal(f3, f7, RV64);
            end
            OPC_OP: begin
                dec_b.flags.wen = 1'b1;
                legal           = op_legal(f3, f7);
            end
            OPC_OP_IMM_32: begin
                dec_fmt         = IMM_I;
                dec_b.flags.wen = 1'b1;
                legal           = RV64 ? op_imm_w_legal(f3, f7)
                                       : (W32_AS_BASE && op_imm_legal(f3, f7, 1'b0));
            end
            OPC_OP_32: begin
                dec_b.flags.wen = 1'b1;
                legal           = RV64 ? op_w_legal(f3, f7)
                                       : (W32_AS_BASE && op_legal(f3, f7));
            end
            OPC_MISC_MEM: legal = 1'b1;
            OPC_SYSTEM: begin
                dec_fmt = IMM_I;
                if (dec_instr == INSTR_ECALL) begin
                    dec_b.flags.ecall = 1'b1;
                    legal             = 1'b1;
                end else if (dec_instr == INSTR_EBREAK) begin
                    dec_b.flags.ebreak = 1'b1;
                    legal              = 1'b1;
                end else if (dec_instr == INSTR_MRET) begin
                    dec_b.flags.mret = 1'b1;
                    legal            = 1'b1;
                end else if ((f3 != 3'b000) && (f3 != 3'b100)) begin
                    dec_b.flags.csr = 1'b1;
                    dec_b.flags.wen = 1'b1;
                    legal           = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase
        if (dec_b.rd == 5'd0) dec_b.flags.wen = 1'b0;
`ifdef YSYX_220053_IDU_ILLEGAL_EN
        if (!legal) begin
            dec_b.flags         = '0;
            dec_b.flags.illegal = 1'b1;
        end
`else
        if (!legal) dec_b.flags = '0;
`endif
    end

    // Queue storage carries no reset; validity lives entirely in qcount/pointers.
    always_ff @(posedge clk) begin
        if (enq && !rst && !flush) begin
            q_pc[wr_ptr]    <= in_pc;
            q_instr[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            qcount      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            state       <= ST_RUN;
            out_valid_r <= 1'b0;
            out_b       <= '0;
            out_pc_r    <= '0;
            out_imm_r   <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            qcount <= qcount + CW'(enq) - CW'(deq);
            if (load) begin
                out_valid_r <= 1'b1;
                out_b       <= dec_b;
                out_pc_r    <= dec_pc;
                out_imm_r   <= dec_imm;
            end else if (out_fire) begin
                out_valid_r <= 1'b0;
            end
            case (state)
                ST_RUN:  if (halt_now) state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

    assign halted      = (state == ST_HALT);
    assign out_valid   = out_valid_r;
    assign out_pc      = out_pc_r;
    assign out_imm     = out_imm_r;
    assign out_rd      = out_b.rd;
    assign out_rs1     = out_b.rs1;
    assign out_rs2     = out_b.rs2;
    assign out_func3   = out_b.func3;
    assign out_func7   = out_b.func7;
    assign out_wen     = out_b.flags.wen;
    assign out_load    = out_b.flags.load;
    assign out_store   = out_b.flags.store;
    assign out_branch  = out_b.flags.branch;
    assign out_jal     = out_b.flags.jal;
    assign out_jalr    = out_b.flags.jalr;
    assign out_csr     = out_b.flags.csr;
    assign out_ecall   = out_b.flags.ecall;
    assign out_mret    = out_b.flags.mret;
    assign out_ebreak  = out_b.flags.ebreak;
    assign out_illegal = out_b.flags.illegal;

endmodule
